// File: rtl/comp_cal_pkg.sv
// Shared types and helpers for the comparator offset-calibration sequencer.
package comp_cal_pkg;

    localparam int CODE_W   = 5;
    localparam int CODE_MAX = 2**CODE_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // The comparator's n-side trim port expects the magnitude MSB-first reversed.
    function automatic logic [CODE_W-1:0] bitrev(input logic [CODE_W-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < CODE_W; i++) r[i] = v[CODE_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/comp_offset_cal_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/comp_offset_cal_ctrl.sv
// Foreground comparator offset calibration: sign decision, then a sign-magnitude
// SAR search of the trim, each decision a majority vote over NSAMP settled samples.
module comp_offset_cal_ctrl #(
    parameter int SETTLE_CYC = 8,
    parameter int NSAMP      = 3,
    parameter int CODE_W     = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              comp_out,
    output logic              cal_short,
    output logic              busy,
    output logic              done,
    output logic              cal_sat,
    output logic              cal_sign,
    output logic [CODE_W-1:0] cfg_offset_p,
    output logic [CODE_W-1:0] cfg_offset_n
);
    import comp_cal_pkg::*;

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int OW = $clog2(NSAMP + 1);
    localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    state_t            state, state_nx;
    logic              cs;
    logic [SW-1:0]     settle_cnt;
    logic [OW-1:0]     samp_cnt, ones, ones_tot;
    logic [BW-1:0]     bit_idx;
    logic [CODE_W-1:0] kept, kept_nx, mag, onehot;
    logic              sign_step, sign, sat;
    logic              go, last_samp, dec, keep;

    sync2 u_sync (.clk(clk), .rstn(rstn), .d(comp_out), .q(cs));

    assign go        = start && (state == IDLE || state == DONE);
    assign last_samp = (samp_cnt == OW'(NSAMP - 1));
    assign ones_tot  = ones + OW'(cs);
    assign dec       = {ones_tot, 1'b0} > (OW+1)'(NSAMP);
    assign onehot    = CODE_W'(1) << bit_idx;
    // A bit survives only while the residual polarity is still the original one.
    assign keep      = (dec == sign);
    assign kept_nx   = keep ? (kept | onehot) : kept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = SET;
            SET:        state_nx = SETTLE;
            SETTLE:     if (settle_cnt == '0) state_nx = SAMPLE;
            SAMPLE:     if (last_samp)
                            state_nx = (!sign_step && bit_idx == '0) ? DONE : SET;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            ones       <= '0;
            bit_idx    <= '0;
            kept       <= '0;
            mag        <= '0;
            sign_step  <= 1'b0;
            sign       <= 1'b0;
            sat        <= 1'b0;
        end else if (go) begin
            samp_cnt   <= '0;
            ones       <= '0;
            bit_idx    <= BW'(CODE_W - 1);
            kept       <= '0;
            mag        <= '0;
            sign_step  <= 1'b1;
            sign       <= 1'b0;
            sat        <= 1'b0;
        end else begin
            case (state)
                SET: begin
                    mag        <= sign_step ? '0 : (kept | onehot);
                    settle_cnt <= SW'(SETTLE_CYC - 1);
                    samp_cnt   <= '0;
                    ones       <= '0;
                end
                SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                SAMPLE: begin
                    if (!last_samp) begin
                        ones     <= ones_tot;
                        samp_cnt <= samp_cnt + 1'b1;
                    end else if (sign_step) begin
                        sign      <= dec;
                        sign_step <= 1'b0;
                    end else begin
                        kept <= kept_nx;
                        if (bit_idx == '0) begin
                            mag <= kept_nx;
                            sat <= keep && (kept_nx == CODE_W'(CODE_MAX));
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        cal_short = 1'b0;
        done      = 1'b0;
        case (state)
            SET, SETTLE, SAMPLE: begin
                busy      = 1'b1;
                cal_short = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        cal_sign     = sign;
        cal_sat      = sat;
        cfg_offset_p = sign ? '0 : mag;
        cfg_offset_n = sign ? bitrev(mag) : '0;
    end

endmodule

// File: tb/tb_comp_offset_cal_ctrl.sv
// Scoreboarded bench: a behavioural comparator with programmable offset closes
// the loop through the trims; expected codes come from the ideal offset math.
module tb_comp_offset_cal_ctrl;

    localparam int LAT = 73;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       comp_out;
    logic       cal_short, busy, done, cal_sat, cal_sign;
    logic [4:0] cfg_offset_p, cfg_offset_n;

    comp_offset_cal_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .comp_out(comp_out),
        .cal_short(cal_short), .busy(busy), .done(done), .cal_sat(cal_sat),
        .cal_sign(cal_sign), .cfg_offset_p(cfg_offset_p), .cfg_offset_n(cfg_offset_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // Comparator: output high when net offset (mV) is >= 0; optional 1-in-3 flips.
    int offset = 0;
    bit noise  = 1'b0;
    int eff;
    always @* begin
        eff      = offset + int'(cfg_offset_p) - int'(rev5(cfg_offset_n));
        comp_out = (eff >= 0) ^ (noise && (cyc % 3 == 0));
    end

    typedef struct {
        logic       sign;
        logic [4:0] p;
        logic [4:0] n;
        logic       sat;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    function automatic exp_t model(input int off);
        exp_t e;
        int   m;
        e.sign = (off >= 0);
        m      = (off >= 0) ? off : -off - 1;
        if (m > 31) m = 31;
        e.p    = e.sign ? 5'd0 : 5'(m);
        e.n    = e.sign ? rev5(5'(m)) : 5'd0;
        e.sat  = (m == 31);
        e.lat  = LAT;
        return e;
    endfunction

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One calibration with start driven right after a clock edge; latency counted
    // from that launching edge to the first edge after which done is seen high.
    task automatic run(input int off, input bit nz, input bit poke);
        int   t0;
        bit   seen;
        exp_t e;
        offset = off;
        noise  = nz;
        @(posedge clk); #1;
        start = 1'b1;
        t0    = cyc;
        sbq.push_back(model(off));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("done_clr", done, 0);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            start = poke && (k == 10 || k == 40);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        e = sbq.pop_front();
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("latency", cyc - t0, e.lat);
            chk("cal_sign", cal_sign, e.sign);
            chk("cfg_p", cfg_offset_p, e.p);
            chk("cfg_n", cfg_offset_n, e.n);
            chk("cal_sat", cal_sat, e.sat);
            chk("busy_end", busy, 0);
            chk("short_end", cal_short, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_short"}, cal_short, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat"}, cal_sat, 0);
        chk({tag, "_sign"}, cal_sign, 0);
        chk({tag, "_p"}, cfg_offset_p, 0);
        chk({tag, "_n"}, cfg_offset_n, 0);
    endtask

    initial begin
        #12;
        chk_all_zero("rst");
        @(negedge clk) rstn = 1'b1;

        run(12, 1'b0, 1'b0);
        run(-7, 1'b0, 1'b0);
        run(0, 1'b0, 1'b0);
        run(40, 1'b0, 1'b0);
        run(31, 1'b0, 1'b0);
        run(-32, 1'b0, 1'b0);

        // Abort mid-run with an asynchronous reset, then recalibrate.
        offset = 12;
        noise  = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        chk("mid_busy", busy, 1);
        chk("mid_sign", cal_sign, 1);
        rstn = 1'b0;
        #1;
        chk_all_zero("abort");
        @(posedge clk); #1 rstn = 1'b1;
        run(12, 1'b0, 1'b0);

        // Noisy comparator and stray starts while busy.
        run(12, 1'b1, 1'b1);
        run(-7, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
